// File: rtl/sample_filter.sv
// -----------------------------------------------------------------------------
// sample_filter
//
// Moving-average filter over signed 8-bit samples. The window holds
// 2**DEPTH_LOG2 samples in a circular buffer. A running sum is updated
// incrementally: the new sample is added and the sample it overwrites is
// subtracted. The average is the sum arithmetic-shifted right by DEPTH_LOG2.
// Slots that have not been written yet hold zero. While the window is filling,
// those empty slots count as zero samples, so the average is not divided by
// fill_count.
//
// Optional feature: define SAMPLE_FILTER_PEAK_HOLD_EN to add the peak_max and
// peak_min outputs. They hold the signed max and min of the raw samples seen
// since the last reset or clear.
//
// Parameters
//   DEPTH_LOG2   log2 of the window length, legal range 1..4
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   data_in      signed sample byte
//   data_valid   single-cycle strobe qualifying data_in
//   clear        synchronous flush of the window (wins over data_valid)
//   data_out     signed windowed average, registered
//   out_valid    one-cycle strobe, high the cycle after an accepted sample
//   full         window holds 2**DEPTH_LOG2 real samples
//   fill_count   number of real samples in the window, 0..2**DEPTH_LOG2
//   peak_max     (SAMPLE_FILTER_PEAK_HOLD_EN) signed max since reset/clear
//   peak_min     (SAMPLE_FILTER_PEAK_HOLD_EN) signed min since reset/clear
// -----------------------------------------------------------------------------
module sample_filter #(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   input  logic       clear,
   output logic [7:0] data_out,
   output logic       out_valid,
   output logic       full,
   output logic [4:0] fill_count
`ifdef SAMPLE_FILTER_PEAK_HOLD_EN
   ,
   output logic [7:0] peak_max,
   output logic [7:0] peak_min
`endif
);

   localparam int         DEPTH      = 1 << DEPTH_LOG2;
   localparam int         SUM_W      = 8 + DEPTH_LOG2;
   localparam logic [4:0] FULL_COUNT = 5'(DEPTH);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_FILLING,
      ST_FULL
   } state_t;

   state_t                  state;
   logic [7:0]              ring [DEPTH];
   logic [DEPTH_LOG2-1:0]   wp;
   logic [SUM_W-1:0]        sum;
   logic [SUM_W-1:0]        next_sum;
   logic [4:0]              fill_next;
   logic                    armed;
   logic                    accept;

   // The sum is kept as a two's-complement bit pattern. Sign-extending both
   // operands to SUM_W makes plain modular add/subtract give the signed
   // result. The true window sum always fits in SUM_W bits.
   assign next_sum  = sum
                    + {{DEPTH_LOG2{data_in[7]}}, data_in}
                    - {{DEPTH_LOG2{ring[wp][7]}}, ring[wp]};
   assign fill_next = fill_count + 5'd1;

   // 'armed' is low for the first edge after reset release. A strobe that
   // arrives in the same cycle rst_n rises is therefore ignored.
   assign accept    = data_valid && !clear && armed;

   // NOTE: every register here, including the ring buffer, has an async reset
   // (the buffer is at most 16 bytes). Stale samples must never leak into the
   // sum after a reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_EMPTY;
         for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
         wp         <= '0;
         sum        <= '0;
         fill_count <= '0;
         full       <= 1'b0;
         data_out   <= 8'h00;
         out_valid  <= 1'b0;
         armed      <= 1'b0;
`ifdef SAMPLE_FILTER_PEAK_HOLD_EN
         peak_max   <= 8'h80;
         peak_min   <= 8'h7F;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout, so every right-hand side
         // sees the pre-edge value of every register.
         armed     <= 1'b1;
         out_valid <= 1'b0;

         if (clear) begin
            state      <= ST_EMPTY;
            for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
            wp         <= '0;
            sum        <= '0;
            fill_count <= '0;
            full       <= 1'b0;
            data_out   <= 8'h00;
`ifdef SAMPLE_FILTER_PEAK_HOLD_EN
            peak_max   <= 8'h80;
            peak_min   <= 8'h7F;
`endif
         end else if (accept) begin
            ring[wp]  <= data_in;
            wp        <= wp + DEPTH_LOG2'(1);
            sum       <= next_sum;
            // Taking bits [DEPTH_LOG2 +: 8] of the SUM_W-bit sum is the
            // arithmetic shift right by DEPTH_LOG2, truncated to 8 bits.
            data_out  <= next_sum[DEPTH_LOG2 +: 8];
            out_valid <= 1'b1;
`ifdef SAMPLE_FILTER_PEAK_HOLD_EN
            if ($signed(data_in) > $signed(peak_max)) peak_max <= data_in;
            if ($signed(data_in) < $signed(peak_min)) peak_min <= data_in;
`endif
            case (state)
               ST_EMPTY, ST_FILLING: begin
                  fill_count <= fill_next;
                  if (fill_next == FULL_COUNT) begin
                     state <= ST_FULL;
                     full  <= 1'b1;
                  end else begin
                     state <= ST_FILLING;
                  end
               end
               ST_FULL: begin
                  // Window stays full. fill_count is saturated.
               end
               default: begin
                  state      <= ST_EMPTY;
                  fill_count <= '0;
                  full       <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/sample_filter.md
SAMPLE_FILTER -- requirements
Module: sample_filter

Interface
REQ-001 Parameter: DEPTH_LOG2, default 3, log2 of the averaging window (window = 2^DEPTH_LOG2 samples); legal values are 1 to 4.
REQ-002 CLK  input  1  system clock, 125.000 MHz; every register is clocked on the rising edge.
REQ-003 RST_N  input  1  reset; asynchronous, active-low.
REQ-004 DATA_IN  input  8  sample byte from spi_controller DATA_OUT, two's-complement signed.
REQ-005 DATA_VALID  input  1  single-cycle strobe; DATA_IN is valid in the same cycle.
REQ-006 CLEAR  input  1  synchronous flush of the window.
REQ-007 DATA_OUT  output  8  windowed average, signed; feeds display DATA_IN.
REQ-008 OUT_VALID  output  1  single-cycle strobe; DATA_OUT was updated this cycle.
REQ-009 FULL  output  1  window holds 2^DEPTH_LOG2 real samples.
REQ-010 FILL_COUNT  output  5  number of real samples in the window, 0 to 2^DEPTH_LOG2.

Function
REQ-011 Circular buffer: 2^DEPTH_LOG2 signed 8-bit entries, write pointer WP of DEPTH_LOG2 bits, running sum SUM of 8+DEPTH_LOG2 bits (signed).
REQ-012 Accepted sample (DATA_VALID=1, CLEAR=0):
- SUM <= SUM + DATA_IN - buf[WP]
- buf[WP] <= DATA_IN
- WP <= WP+1, wrapping from 2^DEPTH_LOG2-1 to 0
REQ-013 Before the window fills, buf[WP] is 0, so the average counts empty slots as zero; there is no divide by FILL_COUNT.
REQ-014 DATA_OUT = SUM arithmetic-shifted right by DATA_OUT's DEPTH_LOG2 (floor toward minus infinity), truncated to 8 bits; the result always fits and never saturates.
REQ-015 Latency: DATA_OUT and OUT_VALID update in the first cycle after the accepting edge, so OUT_VALID is high exactly one cycle after DATA_VALID.
REQ-016 State machine:
- EMPTY -> FILLING on the first accepted sample.
- FILLING -> FULL when FILL_COUNT reaches 2^DEPTH_LOG2.
- FULL stays in FULL.
- Any state -> EMPTY on CLEAR.
- FULL=1 only in state FULL.
REQ-017 FILL_COUNT increments per accepted sample in EMPTY or FILLING and saturates at 2^DEPTH_LOG2 in FULL.
REQ-018 CLEAR=1:
- Zeroes all buf entries, SUM, WP and FILL_COUNT, and sets DATA_OUT to 0x00 at the next edge.
- OUT_VALID stays 0.
REQ-019 CLEAR and DATA_VALID in the same cycle: CLEAR wins, the sample is dropped and no OUT_VALID is produced.
REQ-020 Back-to-back DATA_VALID on consecutive cycles is accepted at full rate with no stall; each sample gives one OUT_VALID.
REQ-021 DATA_VALID=0: all state holds and OUT_VALID=0.

Reset
REQ-022 While RST_N=0:
- buf entries, SUM, WP, FILL_COUNT = 0
- state = EMPTY
- DATA_OUT = 0x00, OUT_VALID = 0, FULL = 0
REQ-023 RST_N asserted mid-window discards all samples immediately; the first sample after release is treated as the first sample.
REQ-024 DATA_VALID in the cycle RST_N rises is ignored.

Configuration
REQ-025 Macro SAMPLE_FILTER_PEAK_HOLD_EN, when defined, adds two ports:
- PEAK_MAX output 8: signed maximum of all raw samples accepted since the last reset or CLEAR.
- PEAK_MIN output 8: signed minimum of all raw samples accepted since the last reset or CLEAR.
- Both update with the same timing as DATA_OUT.
- Reset and CLEAR set PEAK_MAX to 0x80 and PEAK_MIN to 0x7F.
REQ-026 Without SAMPLE_FILTER_PEAK_HOLD_EN, neither port nor its logic exists; all other behaviour is identical.

Verification
REQ-027 Fill, DEPTH_LOG2=3: eight samples of 0x10 -> DATA_OUT after each = 0x02, 0x04, ..., 0x10; FULL=1 and FILL_COUNT=8 after the 8th; eight OUT_VALID pulses, each one cycle after its DATA_VALID.
REQ-028 Wrap: after REQ-027, sample 0x50 -> SUM=192, DATA_OUT=0x18; FILL_COUNT stays 8; WP returns to 1.
REQ-029 Signed floor: from reset, sample 0xFF -> DATA_OUT=0xFF (-1/8 floors to -1); eight samples of 0xFD -> DATA_OUT=0xFD.
REQ-030 Collision and clear: CLEAR and DATA_VALID (0x40) in the same cycle while FULL -> next cycle DATA_OUT=0x00, FULL=0, FILL_COUNT=0, OUT_VALID=0; the next sample 0x40 -> DATA_OUT=0x08.
REQ-031 Reset mid-window: RST_N low for 1 cycle after 3 samples of 0x20 -> all outputs at reset values; sample 0x08 -> DATA_OUT=0x01, FILL_COUNT=1.
REQ-032 SAMPLE_FILTER_PEAK_HOLD_EN defined: samples 0x05, 0xF0, 0x30 -> PEAK_MAX=0x30, PEAK_MIN=0xF0; after CLEAR, PEAK_MAX=0x80 and PEAK_MIN=0x7F.
